// File: rtl/buffer_arbiter.sv
// Round-robin write arbiter in front of a shared buffer; an order-tag queue records
// which requester wrote each word so read data is steered back in write order.
module buffer_arbiter #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned NumReq    = 2,
  parameter int unsigned TagDepth  = 4
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [NumReq-1:0]           ReqValid,
  input  logic [NumReq*DataWidth-1:0] ReqData,
  output logic [NumReq-1:0]           ReqReady,
  output logic [DataWidth-1:0]        BufWData,
  output logic                        BufWInc,
  input  logic                        BufWFull,
  input  logic [DataWidth-1:0]        BufRData,
  output logic                        BufRInc,
  input  logic                        BufREmpty,
  output logic [NumReq-1:0]           RspValid,
  output logic [DataWidth-1:0]        RspData,
  input  logic [NumReq-1:0]           RspReady,
  output logic                        Busy
);

  localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned AddrW = (TagDepth > 1) ? $clog2(TagDepth) : 1;
  localparam int unsigned PtrW  = AddrW + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [IdxW-1:0]   rr_q;
  logic [IdxW-1:0]   tag_mem [TagDepth];
  logic [PtrW-1:0]   tag_wr_q;
  logic [PtrW-1:0]   tag_rd_q;
  logic [PtrW-1:0]   tag_wr_d;
  logic [PtrW-1:0]   tag_rd_d;
  logic [PtrW-1:0]   tag_cnt;
  logic              tag_full;
  logic              tag_empty;
  logic [IdxW-1:0]   tag_head;
  logic              tag_pop;
  logic              busy_q;
  logic              can_write;
  logic              grant_any;
  logic [IdxW-1:0]   grant_idx;
  logic              rd_start;
  logic              rsp_take;
  logic              rd_chain;

  assign tag_cnt   = tag_wr_q - tag_rd_q;
  assign tag_empty = (tag_wr_q == tag_rd_q);
  assign tag_full  = (tag_wr_q[PtrW-1] != tag_rd_q[PtrW-1]) &&
                     (tag_wr_q[AddrW-1:0] == tag_rd_q[AddrW-1:0]);
  assign tag_head  = tag_mem[tag_rd_q[AddrW-1:0]];
  assign tag_wr_d  = tag_wr_q + PtrW'(grant_any);
  assign tag_rd_d  = tag_rd_q + PtrW'(tag_pop);
  assign Busy      = busy_q;

  // Write grant: first valid requester at or after rr_q; held off during reset
  always_comb begin
    can_write = Rst & ~BufWFull & ~tag_full;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      int unsigned cand;
      cand = 32'(rr_q) + k;
      if (cand >= NumReq) cand = cand - NumReq;
      if (!grant_any && ReqValid[IdxW'(cand)]) begin
        grant_any = 1'b1;
        grant_idx = IdxW'(cand);
      end
    end
    grant_any = grant_any & can_write;
  end

  always_comb begin
    ReqReady = '0;
    BufWData = '0;
    BufWInc  = grant_any;
    if (grant_any) begin
      ReqReady[grant_idx] = 1'b1;
      BufWData = ReqData[32'(grant_idx) * DataWidth +: DataWidth];
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rr_q     <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      if (grant_any) begin
        rr_q <= (grant_idx == IdxW'(NumReq - 1)) ? '0 : grant_idx + 1'b1;
      end
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
      busy_q   <= (tag_wr_d != tag_rd_d);
    end
  end

  // Tag storage needs no reset: entries are only read between valid pointers
  always_ff @(posedge Clk) begin
    if (grant_any) tag_mem[tag_wr_q[AddrW-1:0]] <= grant_idx;
  end

  assign rd_start = ~BufREmpty & ~tag_empty;
  assign rsp_take = RspReady[tag_head];
  assign rd_chain = ~BufREmpty & (tag_cnt > PtrW'(1));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (rd_start) state_d = HOLD;
      HOLD: if (rsp_take && !rd_chain) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read side: pop the buffer, then present the word to the tagged requester
  always_comb begin
    BufRInc  = 1'b0;
    RspValid = '0;
    RspData  = '0;
    tag_pop  = 1'b0;
    case (state_q)
      IDLE: BufRInc = rd_start;
      HOLD: begin
        RspValid[tag_head] = 1'b1;
        RspData            = BufRData;
        if (rsp_take) begin
          tag_pop = 1'b1;
          BufRInc = rd_chain;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_buffer_arbiter.sv
// Directed bench for buffer_arbiter with a small behavioural FIFO model on the buffer side.
module tb_buffer_arbiter;

  localparam int DW        = 64;
  localparam int NR        = 2;
  localparam int BUF_DEPTH = 3;

  logic              Clk;
  logic              Rst;
  logic [NR-1:0]     ReqValid;
  logic [NR*DW-1:0]  ReqData;
  logic [NR-1:0]     ReqReady;
  logic [DW-1:0]     BufWData;
  logic              BufWInc;
  logic              BufWFull;
  logic [DW-1:0]     BufRData;
  logic              BufRInc;
  logic              BufREmpty;
  logic [NR-1:0]     RspValid;
  logic [DW-1:0]     RspData;
  logic [NR-1:0]     RspReady;
  logic              Busy;

  int tests;
  int fails;

  logic          force_full;
  logic [DW-1:0] bmem [BUF_DEPTH];
  int            bcnt;
  int            bwp;
  int            brp;

  buffer_arbiter #(.DataWidth(DW), .NumReq(NR), .TagDepth(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .ReqValid(ReqValid), .ReqData(ReqData), .ReqReady(ReqReady),
    .BufWData(BufWData), .BufWInc(BufWInc), .BufWFull(BufWFull),
    .BufRData(BufRData), .BufRInc(BufRInc), .BufREmpty(BufREmpty),
    .RspValid(RspValid), .RspData(RspData), .RspReady(RspReady),
    .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  assign BufWFull  = force_full | (bcnt == BUF_DEPTH);
  assign BufREmpty = (bcnt == 0);

  // Buffer model: registered read data, valid the cycle after RInc
  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      bcnt     <= 0;
      bwp      <= 0;
      brp      <= 0;
      BufRData <= '0;
    end else begin
      if (BufWInc && bcnt < BUF_DEPTH) begin
        bmem[bwp] <= BufWData;
        bwp <= (bwp + 1) % BUF_DEPTH;
      end
      if (BufRInc && bcnt > 0) begin
        BufRData <= bmem[brp];
        brp <= (brp + 1) % BUF_DEPTH;
      end
      bcnt <= bcnt + ((BufWInc && bcnt < BUF_DEPTH) ? 1 : 0) - ((BufRInc && bcnt > 0) ? 1 : 0);
    end
  end

  function automatic logic [DW-1:0] dval(int k, int i);
    return 64'hD00D_0000_0000_0000 | 64'(k << 8) | 64'(i);
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    ReqValid = '0;
    ReqData = '0;
    RspReady = '0;
    force_full = 1'b0;
    step();
    step();
    Rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    ReqValid = 2'b11;
    ReqData = {dval(0, 1), dval(0, 0)};
    #1;
    tests++; if (ReqReady !== 2'b01) begin fails++; $display("FAIL rst_pre_grant0: got %b exp 01", ReqReady); end
    step();
    #1;
    tests++; if (ReqReady !== 2'b10) begin fails++; $display("FAIL rst_pre_grant1: got %b exp 10", ReqReady); end
    tests++; if (BufRInc !== 1'b1) begin fails++; $display("FAIL rst_pre_rinc: got %b exp 1", BufRInc); end
    Rst = 1'b0;
    #1;
    tests++; if (ReqReady !== 2'b00) begin fails++; $display("FAIL rst_reqready: got %b exp 00", ReqReady); end
    tests++; if (BufWInc !== 1'b0) begin fails++; $display("FAIL rst_winc: got %b exp 0", BufWInc); end
    tests++; if (BufRInc !== 1'b0) begin fails++; $display("FAIL rst_rinc: got %b exp 0", BufRInc); end
    tests++; if (RspValid !== 2'b00) begin fails++; $display("FAIL rst_rspvalid: got %b exp 00", RspValid); end
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b exp 0", Busy); end
    tests++; if (BufWData !== '0) begin fails++; $display("FAIL rst_wdata: got %h exp 0", BufWData); end
    tests++; if (RspData !== '0) begin fails++; $display("FAIL rst_rspdata: got %h exp 0", RspData); end
    step();
    Rst = 1'b1;
    #1;
    tests++; if (ReqReady !== 2'b01) begin fails++; $display("FAIL rst_first_grant: got %b exp 01", ReqReady); end
    step();
    ReqValid = '0;
  endtask

  task automatic test_single();
    do_reset();
    step();
    ReqValid = 2'b10;
    ReqData = {64'h0000_0000_0000_A5A5, 64'h0};
    RspReady = 2'b11;
    #1;
    tests++; if (ReqReady !== 2'b10) begin fails++; $display("FAIL single_grant: got %b exp 10", ReqReady); end
    tests++; if (BufWInc !== 1'b1) begin fails++; $display("FAIL single_winc: got %b exp 1", BufWInc); end
    tests++; if (BufWData !== 64'hA5A5) begin fails++; $display("FAIL single_wdata: got %h exp a5a5", BufWData); end
    step();
    ReqValid = '0;
    #1;
    tests++; if (BufRInc !== 1'b1) begin fails++; $display("FAIL single_rinc: got %b exp 1", BufRInc); end
    tests++; if (RspValid !== 2'b00) begin fails++; $display("FAIL single_early_rsp: got %b exp 00", RspValid); end
    tests++; if (Busy !== 1'b1) begin fails++; $display("FAIL single_busy1: got %b exp 1", Busy); end
    step();
    #1;
    tests++; if (RspValid !== 2'b10) begin fails++; $display("FAIL single_rspvalid: got %b exp 10", RspValid); end
    tests++; if (RspData !== 64'hA5A5) begin fails++; $display("FAIL single_rspdata: got %h exp a5a5", RspData); end
    step();
    #1;
    tests++; if (RspValid !== 2'b00) begin fails++; $display("FAIL single_rsp_done: got %b exp 00", RspValid); end
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL single_busy0: got %b exp 0", Busy); end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_oh;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step();
      if (k < 6) begin
        ReqValid = 2'b11;
        ReqData = {dval(k, 1), dval(k, 0)};
      end else begin
        ReqValid = '0;
      end
      RspReady = 2'b11;
      #1;
      if (k < 6) begin
        exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
        tests++; if (ReqReady !== exp_oh) begin fails++; $display("FAIL rr_grant[%0d]: got %b exp %b", k, ReqReady, exp_oh); end
        tests++; if (BufWData !== dval(k, k % 2)) begin fails++; $display("FAIL rr_wdata[%0d]: got %h exp %h", k, BufWData, dval(k, k % 2)); end
      end
      if (k >= 2) begin
        exp_oh = ((k - 2) % 2 == 0) ? 2'b01 : 2'b10;
        tests++; if (RspValid !== exp_oh) begin fails++; $display("FAIL rr_rspvalid[%0d]: got %b exp %b", k, RspValid, exp_oh); end
        tests++; if (RspData !== dval(k - 2, (k - 2) % 2)) begin fails++; $display("FAIL rr_rspdata[%0d]: got %h exp %h", k, RspData, dval(k - 2, (k - 2) % 2)); end
      end else begin
        tests++; if (RspValid !== 2'b00) begin fails++; $display("FAIL rr_rsp_early[%0d]: got %b exp 00", k, RspValid); end
      end
    end
    step();
    #1;
    tests++; if (RspValid !== 2'b00) begin fails++; $display("FAIL rr_end_rsp: got %b exp 00", RspValid); end
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL rr_end_busy: got %b exp 0", Busy); end
  endtask

  task automatic test_backpressure();
    logic [NR-1:0] exp_oh;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      step();
      force_full = 1'b1;
      ReqValid = 2'b11;
      ReqData = {dval(9, 1), dval(9, 0)};
      #1;
      tests++; if (ReqReady !== 2'b00) begin fails++; $display("FAIL bp_full_ready[%0d]: got %b exp 00", k, ReqReady); end
      tests++; if (BufWInc !== 1'b0) begin fails++; $display("FAIL bp_full_winc[%0d]: got %b exp 0", k, BufWInc); end
      tests++; if (BufWData !== '0) begin fails++; $display("FAIL bp_full_wdata[%0d]: got %h exp 0", k, BufWData); end
    end
    for (int k = 0; k < 6; k++) begin
      step();
      force_full = 1'b0;
      RspReady = 2'b00;
      ReqData = {dval(k, 1), dval(k, 0)};
      #1;
      exp_oh = (k >= 4) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
      tests++; if (ReqReady !== exp_oh) begin fails++; $display("FAIL bp_tag_grant[%0d]: got %b exp %b", k, ReqReady, exp_oh); end
      if (k >= 2) begin
        tests++; if (RspValid !== 2'b01) begin fails++; $display("FAIL bp_hold_rsp[%0d]: got %b exp 01", k, RspValid); end
        tests++; if (BufRInc !== 1'b0) begin fails++; $display("FAIL bp_hold_rinc[%0d]: got %b exp 0", k, BufRInc); end
      end
    end
    tests++; if (Busy !== 1'b1) begin fails++; $display("FAIL bp_busy: got %b exp 1", Busy); end
  endtask

  task automatic test_stall();
    do_reset();
    step();
    ReqValid = 2'b01;
    ReqData = {64'h0, 64'h5A5A_0000_1234_5678};
    #1;
    tests++; if (ReqReady !== 2'b01) begin fails++; $display("FAIL stall_grant: got %b exp 01", ReqReady); end
    step();
    ReqValid = '0;
    #1;
    tests++; if (BufRInc !== 1'b1) begin fails++; $display("FAIL stall_rinc: got %b exp 1", BufRInc); end
    for (int k = 0; k < 5; k++) begin
      step();
      RspReady = 2'b10;
      #1;
      tests++; if (RspValid !== 2'b01) begin fails++; $display("FAIL stall_valid[%0d]: got %b exp 01", k, RspValid); end
      tests++; if (RspData !== 64'h5A5A_0000_1234_5678) begin fails++; $display("FAIL stall_data[%0d]: got %h exp 5a5a000012345678", k, RspData); end
      tests++; if (BufRInc !== 1'b0) begin fails++; $display("FAIL stall_norinc[%0d]: got %b exp 0", k, BufRInc); end
    end
    step();
    RspReady = 2'b01;
    #1;
    tests++; if (RspValid !== 2'b01) begin fails++; $display("FAIL stall_release_valid: got %b exp 01", RspValid); end
    tests++; if (BufRInc !== 1'b0) begin fails++; $display("FAIL stall_release_rinc: got %b exp 0", BufRInc); end
    step();
    #1;
    tests++; if (RspValid !== 2'b00) begin fails++; $display("FAIL stall_popped: got %b exp 00", RspValid); end
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL stall_busy: got %b exp 0", Busy); end
  endtask

  task automatic test_back_to_back();
    logic [NR-1:0] oh [3];
    oh[0] = 2'b01;
    oh[1] = 2'b10;
    oh[2] = 2'b01;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step();
      ReqValid = oh[k];
      ReqData = {dval(20 + k, 1), dval(20 + k, 0)};
      #1;
      tests++; if (ReqReady !== oh[k]) begin fails++; $display("FAIL b2b_grant[%0d]: got %b exp %b", k, ReqReady, oh[k]); end
    end
    for (int k = 0; k < 3; k++) begin
      step();
      ReqValid = '0;
      RspReady = 2'b11;
      #1;
      tests++; if (RspValid !== oh[k]) begin fails++; $display("FAIL b2b_valid[%0d]: got %b exp %b", k, RspValid, oh[k]); end
      tests++; if (RspData !== dval(20 + k, k % 2)) begin fails++; $display("FAIL b2b_data[%0d]: got %h exp %h", k, RspData, dval(20 + k, k % 2)); end
      tests++; if (BufRInc !== (k < 2)) begin fails++; $display("FAIL b2b_rinc[%0d]: got %b exp %b", k, BufRInc, (k < 2)); end
    end
    step();
    #1;
    tests++; if (RspValid !== 2'b00) begin fails++; $display("FAIL b2b_idle: got %b exp 00", RspValid); end
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL b2b_busy: got %b exp 0", Busy); end
    tests++; if (BufRInc !== 1'b0) begin fails++; $display("FAIL b2b_rinc_end: got %b exp 0", BufRInc); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    Clk = 1'b0;
    Rst = 1'b0;
    ReqValid = '0;
    ReqData = '0;
    RspReady = '0;
    force_full = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_stall();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
